// File: rtl/beam_path_counter.sv
// beam_path_counter: streams splitter rows through a saturating per-column path grid,
// then reduces the final paths through a pipelined adder tree into a split or path count.
module beam_path_counter #(
  parameter int WIDTH     = 141,
  parameter int ROWS      = 140,
  parameter int START_COL = 70,
  parameter int COUNT_W   = 49
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               mode,
  input  logic               row_valid,
  output logic               row_ready,
  input  logic [WIDTH-1:0]   row_data,
  output logic               busy,
  output logic               finished,
  output logic [COUNT_W-1:0] result,
  output logic               overflow
);
  localparam int L  = $clog2(WIDTH);
  localparam int N  = 1 << L;
  localparam int RW = $clog2(ROWS + 1);
  localparam int PW = $clog2(N + 1);
  localparam int SW = (COUNT_W > PW ? COUNT_W : PW) + 1;
  localparam int CW = $clog2(L + 2);
  localparam logic [COUNT_W-1:0] MAXC = '1;

  typedef enum logic [1:0] {IDLE, LOAD, REDUCE, DONE} state_t;
  state_t state;

  logic [COUNT_W-1:0] path [N];
  logic [COUNT_W-1:0] next_path [N];
  logic [N-1:0]       col_ov;
  logic [N-1:0]       hit;
  logic [RW-1:0]      row_cnt;
  logic [CW-1:0]      red_cnt;
  logic [COUNT_W-1:0] split;
  logic [COUNT_W-1:0] split_next;
  logic               split_ov;
  logic [PW-1:0]      pop;
  logic [SW-1:0]      tot;
  logic               m_q;
  logic [COUNT_W-1:0] nd [1:2*N-1];
  logic               nov [1:2*N-1];
  logic [COUNT_W-1:0] sum_q [1:N-1];
  logic [COUNT_W-1:0] sum_d [1:N-1];
  logic               ov_q [1:N-1];
  logic               ov_d [1:N-1];
  logic [COUNT_W:0]   t_s;

  function automatic logic [COUNT_W:0] sat_add(input logic [COUNT_W-1:0] a, input logic [COUNT_W-1:0] b);
    logic [COUNT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[COUNT_W] ? {1'b1, MAXC} : s;
  endfunction

  // Columns past WIDTH pad the grid to a power of two and stay zero.
  genvar c;
  for (c = 0; c < N; c++) begin : g_col
    if (c < WIDTH) begin : g_in
      logic [COUNT_W-1:0] lt, rt, md;
      logic [COUNT_W:0]   s1, s2;
      if (c > 0) begin : g_l
        assign lt = row_data[c-1] ? path[c-1] : '0;
      end else begin : g_l0
        assign lt = '0;
      end
      if (c < WIDTH - 1) begin : g_r
        assign rt = row_data[c+1] ? path[c+1] : '0;
      end else begin : g_r0
        assign rt = '0;
      end
      assign md = row_data[c] ? '0 : path[c];
      assign s1 = sat_add(lt, rt);
      assign s2 = sat_add(s1[COUNT_W-1:0], md);
      assign next_path[c] = s2[COUNT_W-1:0];
      assign col_ov[c] = s1[COUNT_W] | s2[COUNT_W];
      assign hit[c] = row_data[c] && path[c] != '0;
    end else begin : g_pad
      assign next_path[c] = '0;
      assign col_ov[c] = 1'b0;
      assign hit[c] = 1'b0;
    end
  end

  always_comb begin
    pop = '0;
    for (int i = 0; i < N; i++) pop = pop + PW'(hit[i]);
    tot = SW'(split) + SW'(pop);
    split_ov = tot > SW'(MAXC);
    split_next = split_ov ? MAXC : tot[COUNT_W-1:0];
  end

  // Heap-ordered tree: node i sums nodes 2i and 2i+1, leaves are the path registers.
  always_comb begin
    t_s = '0;
    for (int i = 1; i < N; i++) begin
      nd[i] = sum_q[i];
      nov[i] = ov_q[i];
    end
    for (int i = 0; i < N; i++) begin
      nd[N+i] = path[i];
      nov[N+i] = 1'b0;
    end
    for (int i = 1; i < N; i++) begin
      t_s = sat_add(nd[2*i], nd[2*i+1]);
      sum_d[i] = t_s[COUNT_W-1:0];
      ov_d[i] = t_s[COUNT_W] | nov[2*i] | nov[2*i+1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      row_ready <= 1'b0;
      busy <= 1'b0;
      finished <= 1'b0;
      result <= '0;
      overflow <= 1'b0;
      split <= '0;
      row_cnt <= '0;
      red_cnt <= '0;
      m_q <= 1'b0;
      for (int i = 0; i < N; i++) path[i] <= '0;
      for (int i = 1; i < N; i++) begin
        sum_q[i] <= '0;
        ov_q[i] <= 1'b0;
      end
    end else begin
      sum_q <= sum_d;
      ov_q <= ov_d;
      case (state)
        IDLE, DONE: if (start) begin
          state <= LOAD;
          for (int i = 0; i < N; i++) path[i] <= (i == START_COL) ? COUNT_W'(1) : '0;
          split <= '0;
          overflow <= 1'b0;
          finished <= 1'b0;
          row_cnt <= '0;
          m_q <= mode;
          row_ready <= 1'b1;
          busy <= 1'b1;
        end
        LOAD: if (row_valid) begin
          path <= next_path;
          split <= split_next;
          overflow <= overflow | (|col_ov) | split_ov;
          row_cnt <= row_cnt + 1'b1;
          if (row_cnt == RW'(ROWS - 1)) begin
            state <= REDUCE;
            row_ready <= 1'b0;
            red_cnt <= '0;
          end
        end
        REDUCE: begin
          red_cnt <= red_cnt + 1'b1;
          if (red_cnt == CW'(L)) begin
            state <= DONE;
            busy <= 1'b0;
            finished <= 1'b1;
            result <= m_q ? nd[1] : split;
            overflow <= overflow | ov_q[1];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_beam_path_counter.sv
// tb_beam_path_counter: directed checks of four beam_path_counter configurations
// (small grid, edge source, saturating counts, default size).
module tb_beam_path_counter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic mode = 1'b0;
  logic row_valid = 1'b0;
  logic [4:0] row_data5 = '0;
  logic [140:0] row_data_d = '0;
  logic start_a = 1'b0, start_b = 1'b0, start_c = 1'b0, start_d = 1'b0;
  logic rdy_a, busy_a, fin_a, ovf_a;
  logic rdy_b, busy_b, fin_b, ovf_b;
  logic rdy_c, busy_c, fin_c, ovf_c;
  logic rdy_d, busy_d, fin_d, ovf_d;
  logic [48:0] res_a, res_d;
  logic [7:0]  res_b;
  logic [1:0]  res_c;
  int checks = 0;
  int fails = 0;

  always #5 clk = ~clk;

  beam_path_counter #(.WIDTH(5), .ROWS(2), .START_COL(2), .COUNT_W(49)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .mode(mode), .row_valid(row_valid),
    .row_ready(rdy_a), .row_data(row_data5), .busy(busy_a), .finished(fin_a),
    .result(res_a), .overflow(ovf_a));
  beam_path_counter #(.WIDTH(5), .ROWS(1), .START_COL(0), .COUNT_W(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .mode(mode), .row_valid(row_valid),
    .row_ready(rdy_b), .row_data(row_data5), .busy(busy_b), .finished(fin_b),
    .result(res_b), .overflow(ovf_b));
  beam_path_counter #(.WIDTH(5), .ROWS(3), .START_COL(2), .COUNT_W(2)) dut_c (
    .clk(clk), .rst_n(rst_n), .start(start_c), .mode(mode), .row_valid(row_valid),
    .row_ready(rdy_c), .row_data(row_data5), .busy(busy_c), .finished(fin_c),
    .result(res_c), .overflow(ovf_c));
  beam_path_counter dut_d (
    .clk(clk), .rst_n(rst_n), .start(start_d), .mode(mode), .row_valid(row_valid),
    .row_ready(rdy_d), .row_data(row_data_d), .busy(busy_d), .finished(fin_d),
    .result(res_d), .overflow(ovf_d));

  function automatic int nrows(input int id);
    return id == 0 ? 2 : id == 1 ? 1 : id == 2 ? 3 : 140;
  endfunction

  function automatic logic [4:0] row_of(input int id, input int i);
    return id == 1 ? 5'b00001 : (i == 1 ? 5'b01010 : 5'b00100);
  endfunction

  function automatic logic fin_of(input int id);
    return id == 0 ? fin_a : id == 1 ? fin_b : id == 2 ? fin_c : fin_d;
  endfunction

  task automatic set_start(input int id, input logic v);
    case (id)
      0: start_a = v;
      1: start_b = v;
      2: start_c = v;
      default: start_d = v;
    endcase
  endtask

  // lat = cycles from the last accepting edge to finished, -1 if it never rose
  task automatic drive_run(input int id, input logic m, input int gap, input bit poke, output int lat);
    int k;
    @(negedge clk);
    mode = m;
    set_start(id, 1'b1);
    @(negedge clk);
    set_start(id, 1'b0);
    for (int i = 0; i < nrows(id); i++) begin
      row_data5 = row_of(id, i);
      row_valid = 1'b1;
      @(negedge clk);
      row_valid = 1'b0;
      if (i < nrows(id) - 1) repeat (gap) @(negedge clk);
    end
    k = 1;
    if (poke) begin
      set_start(id, 1'b1);
      @(negedge clk);
      set_start(id, 1'b0);
      k = 2;
    end
    while (!fin_of(id) && k < 200) begin
      @(negedge clk);
      k++;
    end
    lat = fin_of(id) ? k - 1 : -1;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    checks++;
    if ({rdy_a, busy_a, fin_a, ovf_a} !== 4'b0) begin fails++; $display("FAIL reset_flags_a: got %b expected 0000", {rdy_a, busy_a, fin_a, ovf_a}); end
    checks++;
    if (res_a !== 49'd0) begin fails++; $display("FAIL reset_result_a: got %0d expected 0", res_a); end
    checks++;
    if ({rdy_d, busy_d, fin_d, ovf_d, res_d} !== 53'd0) begin fails++; $display("FAIL reset_all_d: got %0h expected 0", {rdy_d, busy_d, fin_d, ovf_d, res_d}); end
    rst_n = 1'b1;
    row_valid = 1'b1;
    row_data5 = 5'b11111;
    repeat (3) @(negedge clk);
    checks++;
    if ({rdy_a, busy_a, fin_a} !== 3'b0) begin fails++; $display("FAIL idle_after_reset: got %b expected 000", {rdy_a, busy_a, fin_a}); end
    row_valid = 1'b0;
  endtask

  task automatic test_paths;
    int lat;
    drive_run(0, 1'b1, 0, 1'b0, lat);
    checks++;
    if (res_a !== 49'd4) begin fails++; $display("FAIL paths_mode1: got %0d expected 4", res_a); end
    checks++;
    if (ovf_a !== 1'b0) begin fails++; $display("FAIL paths_ovf: got %b expected 0", ovf_a); end
    checks++;
    if (lat !== 4) begin fails++; $display("FAIL paths_latency: got %0d expected 4", lat); end
    drive_run(0, 1'b0, 0, 1'b0, lat);
    checks++;
    if (res_a !== 49'd3) begin fails++; $display("FAIL paths_mode0: got %0d expected 3", res_a); end
  endtask

  task automatic test_edge_loss;
    int lat;
    drive_run(1, 1'b1, 0, 1'b0, lat);
    checks++;
    if (res_b !== 8'd1) begin fails++; $display("FAIL edge_mode1: got %0d expected 1", res_b); end
    checks++;
    if (lat !== 4) begin fails++; $display("FAIL edge_latency: got %0d expected 4", lat); end
    drive_run(1, 1'b0, 0, 1'b0, lat);
    checks++;
    if (res_b !== 8'd1) begin fails++; $display("FAIL edge_mode0: got %0d expected 1", res_b); end
  endtask

  task automatic test_saturation;
    int lat;
    drive_run(2, 1'b1, 0, 1'b0, lat);
    checks++;
    if (res_c !== 2'd3) begin fails++; $display("FAIL sat_mode1: got %0d expected 3", res_c); end
    checks++;
    if (ovf_c !== 1'b1) begin fails++; $display("FAIL sat_ovf_mode1: got %b expected 1", ovf_c); end
    drive_run(2, 1'b0, 0, 1'b0, lat);
    checks++;
    if ({ovf_c, res_c} !== 3'b111) begin fails++; $display("FAIL sat_mode0: got ovf=%b res=%0d expected ovf=1 res=3", ovf_c, res_c); end
  endtask

  task automatic test_stall;
    int lat;
    drive_run(0, 1'b1, 3, 1'b0, lat);
    checks++;
    if (res_a !== 49'd4 || lat !== 4) begin fails++; $display("FAIL stall_mode1: got res=%0d lat=%0d expected res=4 lat=4", res_a, lat); end
    drive_run(0, 1'b0, 3, 1'b0, lat);
    checks++;
    if (res_a !== 49'd3) begin fails++; $display("FAIL stall_mode0: got %0d expected 3", res_a); end
  endtask

  task automatic test_start_in_reduce;
    int lat;
    drive_run(0, 1'b1, 0, 1'b1, lat);
    checks++;
    if (res_a !== 49'd4 || lat !== 4) begin fails++; $display("FAIL reduce_start: got res=%0d lat=%0d expected res=4 lat=4", res_a, lat); end
    repeat (3) @(negedge clk);
    checks++;
    if (fin_a !== 1'b1 || res_a !== 49'd4) begin fails++; $display("FAIL done_hold: got fin=%b res=%0d expected fin=1 res=4", fin_a, res_a); end
  endtask

  task automatic test_back_to_back;
    int k;
    row_data5 = 5'b11111;
    row_valid = 1'b1;
    repeat (3) @(negedge clk);
    row_valid = 1'b0;
    checks++;
    if ({rdy_a, fin_a} !== 2'b01 || res_a !== 49'd4) begin fails++; $display("FAIL done_ignores_rows: got rdy=%b fin=%b res=%0d expected 0 1 4", rdy_a, fin_a, res_a); end
    mode = 1'b0;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    checks++;
    if ({fin_a, busy_a, rdy_a} !== 3'b011) begin fails++; $display("FAIL restart_flags: got %b expected 011", {fin_a, busy_a, rdy_a}); end
    for (int i = 0; i < 2; i++) begin
      row_data5 = row_of(0, i);
      row_valid = 1'b1;
      @(negedge clk);
    end
    row_valid = 1'b0;
    k = 0;
    while (!fin_a && k < 50) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (fin_a !== 1'b1 || res_a !== 49'd3) begin fails++; $display("FAIL restart_result: got fin=%b res=%0d expected 1 3", fin_a, res_a); end
  endtask

  task automatic test_midreset;
    int lat;
    @(negedge clk);
    mode = 1'b1;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    row_data5 = 5'b00100;
    row_valid = 1'b1;
    @(negedge clk);
    row_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({rdy_a, busy_a, fin_a, ovf_a} !== 4'b0 || res_a !== 49'd0) begin fails++; $display("FAIL async_reset: got flags=%b res=%0d expected 0000 0", {rdy_a, busy_a, fin_a, ovf_a}, res_a); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (busy_a !== 1'b0) begin fails++; $display("FAIL post_reset_idle: got busy=%b expected 0", busy_a); end
    drive_run(0, 1'b1, 0, 1'b0, lat);
    checks++;
    if (res_a !== 49'd4 || ovf_a !== 1'b0 || lat !== 4) begin fails++; $display("FAIL rerun_after_reset: got res=%0d ovf=%b lat=%0d expected 4 0 4", res_a, ovf_a, lat); end
  endtask

  task automatic test_default_latency;
    int lat;
    drive_run(3, 1'b1, 0, 1'b0, lat);
    checks++;
    if (res_d !== 49'd1 || ovf_d !== 1'b0) begin fails++; $display("FAIL default_result: got res=%0d ovf=%b expected 1 0", res_d, ovf_d); end
    checks++;
    if (lat !== 9) begin fails++; $display("FAIL default_latency: got %0d expected 9", lat); end
  endtask

  initial begin
    test_reset;
    test_paths;
    test_edge_loss;
    test_saturation;
    test_stall;
    test_start_in_reduce;
    test_back_to_back;
    test_midreset;
    test_default_latency;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
